// File: rtl/c2_word_mapper.sv
// rtl/c2_word_mapper.sv - buffers one Hindi word, then emits it through a writable code map
// Optional trailing delimiter beat per word: define C2_SPACE_OUT_EN.
module c2_word_mapper #(
  parameter int CODE_W = 7,
  parameter int MAX_LEN = 8,
  parameter logic [CODE_W-1:0] SPACE_CODE = CODE_W'(7'b0110000)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] hindi,
  output logic              in_ready,
  input  logic              map_we,
  input  logic [CODE_W-1:0] map_addr,
  input  logic [CODE_W-1:0] map_data,
  output logic              out_valid,
  output logic [CODE_W-1:0] r5,
  output logic              out_last,
  input  logic              out_ready,
  output logic              overflow
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int DEPTH = 1 << CODE_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_LEN);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  idx;
  logic [CODE_W-1:0] map_table [DEPTH];
  logic [CODE_W-1:0] buffer [1 << IDX_W];
  logic [CODE_W-1:0] buf_code;
  logic              at_last;
  logic              at_delim;

  assign buf_code = buffer[idx[IDX_W-1:0]];

`ifdef C2_SPACE_OUT_EN
  // idx walks one step past the buffered characters to produce the delimiter beat
  assign at_delim = (idx == count);
  assign at_last  = at_delim;
`else
  assign at_delim = 1'b0;
  assign at_last  = (idx == count - 1'b1);
`endif

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == EMIT);
  assign out_last  = (state == EMIT) && at_last;
  assign r5        = at_delim ? SPACE_CODE : map_table[buf_code];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= COLLECT;
      count    <= '0;
      idx      <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        map_table[k] <= CODE_W'(k);
      end
    end else begin
      if (map_we) begin
        map_table[map_addr] <= map_data;
      end
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (hindi == SPACE_CODE) begin
              if (count != '0) begin
                state <= EMIT;
                idx   <= '0;
              end
            end else if (count == FULL) begin
              overflow <= 1'b1;
            end else begin
              buffer[count[IDX_W-1:0]] <= hindi;
              count                    <= count + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (at_last) begin
              state <= COLLECT;
              count <= '0;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_c2_word_mapper.sv
// tb/tb_c2_word_mapper.sv - self-checking bench for c2_word_mapper
// Directed vector table, hand-written stall/reset sequences, randomized words vs. a word-level model.
module tb_c2_word_mapper;
  localparam int ML = 8;
  localparam logic [6:0] SP = 7'b0110000;

  typedef logic [6:0] code_q_t[$];

  typedef struct {
    int          n;
    logic [83:0] codes;
    int          nexp;
    logic [83:0] exp;
    logic        ovf;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] hindi = '0;
  logic       in_ready;
  logic       map_we = 1'b0;
  logic [6:0] map_addr = '0;
  logic [6:0] map_data = '0;
  logic       out_valid;
  logic [6:0] r5;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       overflow;

  int   n_pass = 0;
  int   n_total = 0;
  int   ready_mode = 0;
  logic man_ready = 1'b0;
  logic seen_valid = 1'b0;
  logic ovf_model = 1'b0;

  logic [6:0] ref_map [128];
  logic [6:0] got_code[$];
  logic       got_last[$];

  c2_word_mapper #(.CODE_W(7), .MAX_LEN(ML), .SPACE_CODE(SP)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .hindi(hindi),
    .in_ready(in_ready), .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .out_valid(out_valid), .r5(r5), .out_last(out_last), .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = man_ready;
    endcase
  end

  always @(negedge clock) begin
    if (!reset && out_valid) seen_valid = 1'b1;
    if (!reset && out_valid && out_ready) begin
      got_code.push_back(r5);
      got_last.push_back(out_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 128; k++) ref_map[k] = 7'(k);
    ovf_model = 1'b0;
  endtask

  function automatic code_q_t model_word(input code_q_t w);
    code_q_t e;
    foreach (w[i]) if (e.size() < ML) e.push_back(ref_map[w[i]]);
`ifdef C2_SPACE_OUT_EN
    e.push_back(SP);
`endif
    return e;
  endfunction

  task automatic send(input logic [6:0] c);
    int cyc = 0;
    @(posedge clock); #1;
    in_valid = 1'b1;
    hindi = c;
    while (!in_ready && cyc < 1000) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (cyc >= 1000) check("send_timeout", 0, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input code_q_t w);
    foreach (w[i]) send(w[i]);
    send(SP);
    if (w.size() > ML) ovf_model = 1'b1;
  endtask

  task automatic map_write(input logic [6:0] a, input logic [6:0] d);
    @(posedge clock); #1;
    map_we = 1'b1; map_addr = a; map_data = d;
    @(posedge clock); #1;
    map_we = 1'b0;
    ref_map[a] = d;
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while ((got_code.size() < n || !in_ready) && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 1000) check("wait_beats_timeout", got_code.size(), n);
  endtask

  task automatic check_word(input string nm, input code_q_t exp);
    int m;
    check({nm, "_len"}, got_code.size(), exp.size());
    m = (got_code.size() < exp.size()) ? got_code.size() : exp.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s_r5_b%0d", nm, i), 32'(got_code[i]), 32'(exp[i]));
      check($sformatf("%s_last_b%0d", nm, i), 32'(got_last[i]), (i == exp.size() - 1) ? 1 : 0);
    end
    got_code.delete();
    got_last.delete();
  endtask

  initial begin
    vec_t    vecs[4];
    code_q_t w;
    code_q_t e;
    logic [6:0] held;

    // REQ-036 word, single char, exactly MAX_LEN, MAX_LEN+2 (overflow last: it is sticky)
    vecs[0] = '{n: 3, codes: 84'({7'b1011100, 7'b0000000, 7'b1010011}),
                nexp: 3, exp: 84'({7'b1011100, 7'b0000000, 7'b1010011}), ovf: 1'b0};
    vecs[1] = '{n: 1, codes: 84'(7'b1111111), nexp: 1, exp: 84'(7'b1111111), ovf: 1'b0};
    vecs[2] = '{n: 8, codes: '0, nexp: 8, exp: '0, ovf: 1'b0};
    vecs[3] = '{n: 10, codes: '0, nexp: 8, exp: '0, ovf: 1'b1};
    for (int i = 0; i < 8; i++) begin
      vecs[2].codes[i*7 +: 7] = 7'(i);
      vecs[2].exp[i*7 +: 7]   = 7'(i);
      vecs[3].exp[i*7 +: 7]   = 7'(10 + i);
    end
    for (int i = 0; i < 10; i++) vecs[3].codes[i*7 +: 7] = 7'(10 + i);

    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_overflow", 32'(overflow), 0);

    ready_mode = 0;
    for (int v = 0; v < 4; v++) begin
      w.delete(); e.delete();
      for (int i = 0; i < vecs[v].n; i++) w.push_back(vecs[v].codes[i*7 +: 7]);
      for (int i = 0; i < vecs[v].nexp; i++) e.push_back(vecs[v].exp[i*7 +: 7]);
`ifdef C2_SPACE_OUT_EN
      e.push_back(SP);
`endif
      send_word(w);
      wait_beats(e.size());
      check_word($sformatf("vec%0d", v), e);
      check($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(vecs[v].ovf));
    end

    // empty-buffer spaces are swallowed
    seen_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(SP);
      check($sformatf("space%0d_in_ready", i), 32'(in_ready), 1);
    end
    repeat (3) @(negedge clock);
    check("spaces_no_valid", 32'(seen_valid), 0);
    check("spaces_no_beats", got_code.size(), 0);

    // remapped word; overflow from the previous word must still be set
    map_write(7'b1010011, 7'b1000010);
    map_write(7'b1011100, 7'b1001101);
    map_write(7'b0000001, 7'b0010101);
    w = '{7'b1010011, 7'b0000000, 7'b1011100, 7'b0000001};
    e = '{7'b1000010, 7'b0000000, 7'b1001101, 7'b0010101};
`ifdef C2_SPACE_OUT_EN
    e.push_back(SP);
`endif
    send_word(w);
    wait_beats(e.size());
    check_word("mapped", e);
    check("overflow_sticky", 32'(overflow), 1);

    // backpressure mid-word, then a same-cycle write to the code on display
    ready_mode = 2;
    man_ready = 1'b0;
    w = '{7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
    e = model_word(w);
    send_word(w);
    @(posedge clock);
    man_ready = 1'b1;
    repeat (2) @(posedge clock);
    man_ready = 1'b0;
    @(negedge clock);
    held = r5;
    check("stall_r5_start", 32'(held), 32'(ref_map[7'h07]));
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("stall%0d_r5", i), 32'(r5), 32'(held));
      check($sformatf("stall%0d_out_valid", i), 32'(out_valid), 1);
      check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 0);
    end
    @(posedge clock); #1;
    map_we = 1'b1; map_addr = 7'h07; map_data = 7'h55;
    @(negedge clock);
    check("wr_same_cycle_old", 32'(r5), 32'(held));
    @(posedge clock); #1;
    map_we = 1'b0;
    ref_map[7'h07] = 7'h55;
    e[2] = 7'h55;
    @(negedge clock);
    check("wr_next_cycle_new", 32'(r5), 32'h55);
    ready_mode = 0;
    wait_beats(e.size());
    check_word("stall", e);

    // reset during the second beat; the map write in the reset cycle is dropped
    ready_mode = 2;
    man_ready = 1'b0;
    w = '{7'b1010011, 7'b0000000, 7'b1011100};
    send_word(w);
    @(posedge clock);
    man_ready = 1'b1;
    @(posedge clock);
    man_ready = 1'b0;
    #1;
    reset = 1'b1;
    map_we = 1'b1; map_addr = 7'b0000000; map_data = 7'b1111111;
    @(posedge clock); #1;
    reset = 1'b0;
    map_we = 1'b0;
    model_reset();
    @(negedge clock);
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_overflow", 32'(overflow), 0);
    check("rst_mid_in_ready", 32'(in_ready), 1);
    check("rst_mid_beats_before", got_code.size(), 1);
    if (got_code.size() > 0) check("rst_mid_beat0", 32'(got_code[0]), 32'b1000010);
    got_code.delete(); got_last.delete();
    seen_valid = 1'b0;
    ready_mode = 0;
    repeat (4) @(negedge clock);
    check("rst_mid_no_valid", 32'(seen_valid), 0);
    e = '{7'b1010011, 7'b0000000, 7'b1011100};
`ifdef C2_SPACE_OUT_EN
    e.push_back(SP);
`endif
    send_word(w);
    wait_beats(e.size());
    check_word("post_reset", e);

    // randomized words, map writes and downstream stalls
    ready_mode = 1;
    for (int t = 0; t < 30; t++) begin
      int nw;
      int len;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) map_write(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      len = $urandom_range(1, 10);
      w.delete();
      for (int i = 0; i < len; i++) begin
        logic [6:0] c;
        c = 7'($urandom_range(0, 127));
        while (c == SP) c = 7'($urandom_range(0, 127));
        w.push_back(c);
      end
      e = model_word(w);
      send_word(w);
      wait_beats(e.size());
      check_word($sformatf("rnd%0d", t), e);
      check($sformatf("rnd%0d_overflow", t), 32'(overflow), 32'(ovf_model));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
